// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and long-latency writebacks onto the regfile write port (we3/wa3/wd3).
// Optional WB_BYPASS_EN adds combinational read forwarding from the write port.
module wb_arbiter #(
   parameter int XLEN = 32,
   parameter int AW = 5,
   parameter int DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic alu_we,
   input  logic [AW-1:0] alu_wa,
   input  logic [XLEN-1:0] alu_wd,
   output logic alu_stall,
   input  logic ll_valid,
   output logic ll_ready,
   input  logic [AW-1:0] ll_wa,
   input  logic [XLEN-1:0] ll_wd,
   output logic we3,
   output logic [AW-1:0] wa3,
   output logic [XLEN-1:0] wd3,
`ifdef WB_BYPASS_EN
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   output logic [XLEN-1:0] fwd1,
   output logic [XLEN-1:0] fwd2,
`endif
   output logic [$clog2(DEPTH+1)-1:0] ll_count,
   output logic err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = $clog2(STARVE_MAX+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
   logic [DEPTH-1:0] v;
   logic [AW-1:0] wa_q [DEPTH];
   logic [XLEN-1:0] wd_q [DEPTH];
   logic [PW-1:0] head, tail;
   logic [SW-1:0] starve;
   logic ne, alu_win, pop, store, starved;
   always_comb begin
      ne = ll_count != '0;
      ll_ready = reset_n && ll_count != FULL;
      alu_win = !alu_stall && alu_we && alu_wa != '0;
      pop = ne && !alu_win;
      store = ll_valid && ll_ready && ll_wa != '0;
      starved = ne && alu_win && starve + 1'b1 == SMAX;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v <= '0;
         head <= '0;
         tail <= '0;
         ll_count <= '0;
         starve <= '0;
         alu_stall <= 1'b0;
         err <= 1'b0;
         we3 <= 1'b0;
         wa3 <= '0;
         wd3 <= '0;
      end else begin
         // a winning ALU write is younger than anything queued for the same register
         for (int i = 0; i < DEPTH; i++)
            if (alu_win && wa_q[i] == alu_wa) v[i] <= 1'b0;
         // the entry pushed this cycle overrides the kill above
         if (store) begin
            v[tail] <= 1'b1;
            wa_q[tail] <= ll_wa;
            wd_q[tail] <= ll_wd;
            tail <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         ll_count <= ll_count + CW'(store) - CW'(pop);
         starve <= (pop || !ne || starved) ? '0 : starve + 1'b1;
         alu_stall <= starved;
         err <= err || (alu_we && alu_stall);
         we3 <= pop ? v[head] : alu_win;
         if (pop || alu_win) begin
            wa3 <= pop ? wa_q[head] : alu_wa;
            wd3 <= pop ? wd_q[head] : alu_wd;
         end
      end
   end
`ifdef WB_BYPASS_EN
   always_comb begin
      fwd1 = (we3 && wa3 == ra1 && ra1 != '0) ? wd3 : rd1;
      fwd2 = (we3 && wa3 == ra2 && ra2 != '0) ? wd3 : rd2;
   end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors plus a short random run, checked every cycle against a queue model.
module tb_wb_arbiter;
   localparam int XLEN = 32, AW = 5, DEPTH = 2, STARVE_MAX = 4;
   logic clk = 1'b0, reset_n = 1'b0, alu_we = 1'b0, ll_valid = 1'b0;
   logic [AW-1:0] alu_wa = '0, ll_wa = '0;
   logic [XLEN-1:0] alu_wd = '0, ll_wd = '0;
   logic alu_stall, ll_ready, we3, err;
   logic [AW-1:0] wa3;
   logic [XLEN-1:0] wd3;
   logic [1:0] ll_count;
`ifdef WB_BYPASS_EN
   logic [AW-1:0] ra1 = '0, ra2 = '0;
   logic [XLEN-1:0] rd1 = '0, rd2 = '0, fwd1, fwd2;
`endif
   int n_cmp = 0, n_bad = 0;
   logic chk_on = 1'b0;

   wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset_n(reset_n), .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
      .alu_stall(alu_stall), .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
      .we3(we3), .wa3(wa3), .wd3(wd3),
`ifdef WB_BYPASS_EN
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .fwd1(fwd1), .fwd2(fwd2),
`endif
      .ll_count(ll_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: FIFO as a queue of entries, starvation as a plain count of ALU wins
   typedef struct { bit v; logic [AW-1:0] wa; logic [XLEN-1:0] wd; } ent_t;
   ent_t q[$];
   ent_t m_e;
   logic m_we, m_stall, m_err;
   logic [AW-1:0] m_wa;
   logic [XLEN-1:0] m_wd;
   int m_starve, m_n;
   bit m_win;

   always @(posedge clk) begin
      if (!reset_n) begin
         q.delete();
         m_we = 0; m_wa = '0; m_wd = '0; m_stall = 0; m_err = 0; m_starve = 0;
      end else begin
         m_n = q.size();
         m_win = !m_stall && alu_we && alu_wa != 0;
         if (alu_we && m_stall) m_err = 1;
         if (m_n > 0 && !m_win) begin
            m_e = q.pop_front();
            m_we = m_e.v; m_wa = m_e.wa; m_wd = m_e.wd;
         end else if (m_win) begin
            m_we = 1; m_wa = alu_wa; m_wd = alu_wd;
            foreach (q[i]) if (q[i].wa == alu_wa) q[i].v = 0;
         end else m_we = 0;
         m_starve = (m_n > 0 && m_win) ? m_starve + 1 : 0;
         m_stall = m_starve == STARVE_MAX;
         if (m_stall) m_starve = 0;
         if (ll_valid && m_n < DEPTH && ll_wa != 0) q.push_back('{1'b1, ll_wa, ll_wd});
      end
   end

   always @(negedge clk) if (chk_on) begin
      chk("we3", we3, m_we);
      chk("wa3", wa3, m_wa);
      chk("wd3", wd3, m_wd);
      chk("alu_stall", alu_stall, m_stall);
      chk("err", err, m_err);
      chk("ll_count", ll_count, q.size());
      chk("ll_ready", ll_ready, reset_n && q.size() < DEPTH);
   end

   task automatic tick(); @(posedge clk); #2; endtask
   task automatic alu(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      alu_we = we; alu_wa = wa; alu_wd = wd;
   endtask
   task automatic ll(input logic vld, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      ll_valid = vld; ll_wa = wa; ll_wd = wd;
   endtask

   initial begin
      ll(1, 1, 32'h1);
      tick();
      chk_on = 1'b1;
      tick();
      chk("rst_we3", we3, 0); chk("rst_ready", ll_ready, 0); chk("rst_count", ll_count, 0);
      chk("rst_err", err, 0); chk("rst_stall", alu_stall, 0); chk("rst_wa3", wa3, 0);
      reset_n = 1'b1; ll(0, 0, 0);
      alu(1, 3, 32'h11); tick();
      chk("alu_we3", we3, 1); chk("alu_wa3", wa3, 3); chk("alu_wd3", wd3, 32'h11);
      alu(1, 0, 32'h22); tick();
      chk("x0_we3", we3, 0); chk("x0_wa3_hold", wa3, 3); chk("x0_wd3_hold", wd3, 32'h11);
      chk("x0_ready", ll_ready, 1);
      alu(1, 1, 32'h100); ll(1, 5, 32'hA); tick();
      chk("fill1_wa3", wa3, 1); chk("fill1_count", ll_count, 1);
      alu(1, 2, 32'h200); ll(1, 6, 32'hB); tick();
      chk("fill2_wa3", wa3, 2); chk("full_count", ll_count, 2); chk("full_ready", ll_ready, 0);
      alu(0, 0, 0); ll(1, 8, 32'hC); tick();
      chk("drain1_we3", we3, 1); chk("drain1_wa3", wa3, 5); chk("drain1_wd3", wd3, 32'hA);
      chk("full_nopush", ll_count, 1);
      ll(0, 0, 0); tick();
      chk("drain2_wa3", wa3, 6); chk("drain2_wd3", wd3, 32'hB); chk("drain2_count", ll_count, 0);
      tick();
      chk("idle_we3", we3, 0); chk("idle_wa3", wa3, 6);
      alu(1, 10, 32'h3); ll(1, 7, 32'h1); tick();
      chk("waw_q_wa3", wa3, 10);
      alu(1, 7, 32'h2); ll(0, 0, 0); tick();
      chk("waw_alu_we3", we3, 1); chk("waw_alu_wa3", wa3, 7); chk("waw_alu_wd3", wd3, 32'h2);
      alu(0, 0, 0); tick();
      chk("waw_kill_we3", we3, 0); chk("waw_kill_wa3", wa3, 7); chk("waw_kill_count", ll_count, 0);
      alu(1, 12, 32'h4); ll(1, 12, 32'h5); tick();
      chk("same_alu_wd3", wd3, 32'h4);
      alu(0, 0, 0); ll(0, 0, 0); tick();
      chk("same_pop_we3", we3, 1); chk("same_pop_wa3", wa3, 12); chk("same_pop_wd3", wd3, 32'h5);
      ll(1, 0, 32'h77); tick();
      chk("llx0_count", ll_count, 0); chk("llx0_we3", we3, 0);
      alu(1, 11, 32'h1000); ll(1, 9, 32'h99); tick();
      ll(0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         alu(1, 11, 32'h1000 + i); tick();
         chk("starve_stall", alu_stall, (i == 4) ? 1 : 0);
         chk("starve_wd3", wd3, 32'h1000 + i);
      end
      alu(1, 11, 32'h1005); tick();
      chk("forced_we3", we3, 1); chk("forced_wa3", wa3, 9); chk("forced_wd3", wd3, 32'h99);
      chk("forced_err", err, 1); chk("forced_stall_clr", alu_stall, 0);
      alu(1, 11, 32'h1006); tick();
      chk("post_wd3", wd3, 32'h1006); chk("err_sticky", err, 1);
      alu(0, 0, 0); ll(1, 13, 32'hD); tick();
      chk("mid_count", ll_count, 1); chk("mid_we3", we3, 0);
      ll(0, 0, 0); reset_n = 1'b0; tick();
      chk("mid_rst_count", ll_count, 0); chk("mid_rst_err", err, 0); chk("mid_rst_we3", we3, 0);
      reset_n = 1'b1; tick();
      chk("mid_rst_nowrite", we3, 0);
`ifdef WB_BYPASS_EN
      alu(1, 4, 32'h55); tick();
      alu(0, 0, 0);
      ra1 = 4; rd1 = 0; ra2 = 0; rd2 = 32'h77; #1;
      chk("fwd1_hit", fwd1, 32'h55); chk("fwd2_x0", fwd2, 32'h77);
      ra1 = 3; rd1 = 32'h33; #1;
      chk("fwd1_miss", fwd1, 32'h33);
      ra1 = 0; ra2 = 0; rd1 = 0; rd2 = 0;
`endif
      for (int i = 0; i < 300; i++) begin
         alu(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
         ll(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
         tick();
      end
      alu(0, 0, 0); ll(0, 0, 0);
      tick(); tick(); tick();
      chk("final_count", ll_count, 0);
      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
